// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_types_pkg
//  Brief    : Shared CPU types: word type, RAM status codes, and the memory
//             arbiter state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    // Native machine word of the single-cycle datapath
    typedef logic [31:0] word_t;

    // Status reported by the unified RAM each cycle
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Memory arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_D = 2'd1,
        GNT_I = 2'd2
    } arb_state_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Shares the single-port unified RAM between instruction fetch
//             and data access. Data wins ties; a grant is held until the RAM
//             reports ACCESS or ERROR, and every grant is followed by one
//             IDLE bubble cycle. A sticky tmo flag records any grant that
//             stays outstanding for TIMEOUT_CYC cycles.
//             Optional build macro MEM_ARB_STATS_EN adds the icnt/dcnt/scnt
//             access and stall counters.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    // instruction requester
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    // data requester
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    // unified RAM
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  ramstate_t         ramstate,
    // status
    output logic              tmo
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]       icnt,
    output logic [31:0]       dcnt,
    output logic [31:0]       scnt
`endif
);

    localparam int                 c_CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_TMO_MAX = c_CNT_W'(TIMEOUT_CYC);

    arb_state_t          r_state;
    logic [c_CNT_W-1:0]  r_tmo_cnt;
    logic                r_tmo;
    logic [WORD_W-1:0]   r_iload;
    logic [WORD_W-1:0]   r_dload;

    logic w_dreq;
    logic w_ram_done;
    logic w_d_done;
    logic w_i_done;

    // ERROR ends a transaction just like ACCESS; only the returned data differs
    assign w_dreq     = dREN | dWEN;
    assign w_ram_done = (ramstate == ACCESS) || (ramstate == ERROR);
    assign w_d_done   = (r_state == GNT_D) && w_dreq && w_ram_done;
    assign w_i_done   = (r_state == GNT_I) && iREN && w_ram_done;

    assign iload = r_iload;
    assign dload = r_dload;
    assign tmo   = r_tmo;

    // RAM strobes and wait signals follow the live request of the granted side
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = iREN;
        dwait    = w_dreq;
        case (r_state)
            GNT_D: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = ~w_d_done;
            end
            GNT_I: begin
                ramREN   = iREN;
                ramaddr  = iaddr;
                iwait    = ~w_i_done;
            end
            default: ;
        endcase
    end

    // Grant sequencing and read-data capture on completion
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_iload <= '0;
            r_dload <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_dreq)
                        r_state <= GNT_D;
                    else if (iREN)
                        r_state <= GNT_I;
                end
                GNT_D: begin
                    if (!w_dreq) begin
                        r_state <= IDLE;
                    end else if (w_ram_done) begin
                        r_dload <= (ramstate == ACCESS) ? ramload : '0;
                        r_state <= IDLE;
                    end
                end
                GNT_I: begin
                    if (!iREN) begin
                        r_state <= IDLE;
                    end else if (w_ram_done) begin
                        r_iload <= (ramstate == ACCESS) ? ramload : '0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Grant-age counter: saturates at TIMEOUT_CYC and latches the sticky flag
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_tmo_cnt <= '0;
            r_tmo     <= 1'b0;
        end else if (r_state == IDLE) begin
            r_tmo_cnt <= '0;
        end else if (r_tmo_cnt != c_TMO_MAX) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (r_tmo_cnt == c_TMO_MAX - 1'b1)
                r_tmo <= 1'b1;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] r_icnt;
    logic [31:0] r_dcnt;
    logic [31:0] r_scnt;

    assign icnt = r_icnt;
    assign dcnt = r_dcnt;
    assign scnt = r_scnt;

    // Completed-access and stall-cycle counters, free-running with wrap
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_icnt <= '0;
            r_dcnt <= '0;
            r_scnt <= '0;
        end else begin
            if (w_i_done)
                r_icnt <= r_icnt + 32'd1;
            if (w_d_done)
                r_dcnt <= r_dcnt + 32'd1;
            if (iwait | dwait)
                r_scnt <= r_scnt + 32'd1;
        end
    end
`endif

endmodule : mem_arbiter
`default_nettype wire
